// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the 7-segment encode/readback path.
//   Segment patterns are active-high, seg[6]=a .. seg[0]=g.
//   BCD_BLANK marks an unlit position and BCD_INVALID an unrecognised pattern.
package seg7_pkg;

    // Segment bit positions within the 7-bit bus
    localparam int unsigned SEG_A_BIT = 6;
    localparam int unsigned SEG_B_BIT = 5;
    localparam int unsigned SEG_C_BIT = 4;
    localparam int unsigned SEG_D_BIT = 3;
    localparam int unsigned SEG_E_BIT = 2;
    localparam int unsigned SEG_F_BIT = 1;
    localparam int unsigned SEG_G_BIT = 0;

    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] BCD_BLANK   = 4'hF;
    localparam logic [3:0] BCD_INVALID = 4'hE;

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: combinational segment-pattern to code decoder.
//   seg     in  7  active-high segment pattern, seg[6]=a .. seg[0]=g
//   code    out 4  0..9, BCD_BLANK for all-off, BCD_INVALID otherwise
//   invalid out 1  pattern is neither a digit nor blank
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] code,
    output logic       invalid
);

    always_comb begin
        invalid = 1'b0;
        case (seg)
            SEG_0:     code = 4'd0;
            SEG_1:     code = 4'd1;
            SEG_2:     code = 4'd2;
            SEG_3:     code = 4'd3;
            SEG_4:     code = 4'd4;
            SEG_5:     code = 4'd5;
            SEG_6:     code = 4'd6;
            SEG_7:     code = 4'd7;
            SEG_8:     code = 4'd8;
            SEG_9:     code = 4'd9;
            SEG_BLANK: code = BCD_BLANK;
            default: begin
                code    = BCD_INVALID;
                invalid = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader: recovers BCD digits from a multiplexed 7-segment bus.
//   clk, rst     clock, synchronous active-high reset
//   seg          segment bus (active-high), dig_sel one-hot digit select
//   digit_valid  pulse per accepted digit, with digit_idx / digit_bcd
//   bcd_out      last complete frame, digit i in bits [4i+3:4i]
//   frame_valid  pulse when bcd_out updates, frame_err flags a bad pattern
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    digit_valid,
    output logic [2:0]              digit_idx,
    output logic [3:0]              digit_bcd,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic                    frame_valid,
    output logic                    frame_err
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

    logic [6:0]              seg_q, seg_prev_q;
    logic [NUM_DIGITS-1:0]   sel_q, sel_prev_q;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;
    logic                    err_q, err_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic                    digit_valid_q, digit_valid_d;
    logic [2:0]              digit_idx_q, digit_idx_d;
    logic [3:0]              digit_bcd_q, digit_bcd_d;
    logic [4*NUM_DIGITS-1:0] bcd_out_q, bcd_out_d;
    logic                    frame_valid_q, frame_valid_d;
    logic                    frame_err_q, frame_err_d;

    logic [3:0] code;
    logic       invalid;
    logic       one_hot;
    logic       stable;
    logic       accept;
    logic [2:0] sel_idx;
    logic [NUM_DIGITS-1:0]   seen_next;
    logic [4*NUM_DIGITS-1:0] shadow_next;

    seg7_pattern_decode u_decode (
        .seg     (seg_q),
        .code    (code),
        .invalid (invalid)
    );

    always_comb begin
        one_hot = (sel_q != '0) && ((sel_q & (sel_q - 1'b1)) == '0);
        stable  = one_hot && (seg_q == seg_prev_q) && (sel_q == sel_prev_q);

        cnt_d = '0;
        if (stable)
            cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
        else if (one_hot)
            cnt_d = CW'(1);

        // A dwell already at saturation must not re-accept; a fresh pattern
        // reaching the limit (possible when the limit is 1) still accepts.
        accept = one_hot && (cnt_d == CNT_MAX) && !(stable && (cnt_q == CNT_MAX));

        sel_idx     = '0;
        shadow_next = shadow_q;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (sel_q[i]) begin
                sel_idx                = 3'(i);
                shadow_next[4*i +: 4]  = code;
            end
        end
        seen_next = seen_q | sel_q;

        seen_d        = seen_q;
        err_d         = err_q;
        shadow_d      = shadow_q;
        digit_valid_d = 1'b0;
        digit_idx_d   = digit_idx_q;
        digit_bcd_d   = digit_bcd_q;
        bcd_out_d     = bcd_out_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;

        if (accept) begin
            digit_valid_d = 1'b1;
            digit_idx_d   = sel_idx;
            digit_bcd_d   = code;
            shadow_d      = shadow_next;
            if (&seen_next) begin
                bcd_out_d     = shadow_next;
                frame_valid_d = 1'b1;
                frame_err_d   = err_q | invalid;
                seen_d        = '0;
                err_d         = 1'b0;
            end else begin
                seen_d = seen_next;
                err_d  = err_q | invalid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q         <= '0;
            seg_prev_q    <= '0;
            sel_q         <= '0;
            sel_prev_q    <= '0;
            cnt_q         <= '0;
            seen_q        <= '0;
            err_q         <= 1'b0;
            shadow_q      <= '0;
            digit_valid_q <= 1'b0;
            digit_idx_q   <= '0;
            digit_bcd_q   <= '0;
            bcd_out_q     <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            seg_q         <= seg;
            seg_prev_q    <= seg_q;
            sel_q         <= dig_sel;
            sel_prev_q    <= sel_q;
            cnt_q         <= cnt_d;
            seen_q        <= seen_d;
            err_q         <= err_d;
            shadow_q      <= shadow_d;
            digit_valid_q <= digit_valid_d;
            digit_idx_q   <= digit_idx_d;
            digit_bcd_q   <= digit_bcd_d;
            bcd_out_q     <= bcd_out_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign digit_valid = digit_valid_q;
    assign digit_idx   = digit_idx_q;
    assign digit_bcd   = digit_bcd_q;
    assign bcd_out     = bcd_out_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
module tb_seg7_scan_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg = '0;
    logic [3:0]  dig_sel = '0;
    logic        digit_valid;
    logic [2:0]  digit_idx;
    logic [3:0]  digit_bcd;
    logic [15:0] bcd_out;
    logic        frame_valid;
    logic        frame_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [2:0]  idx;
        logic [3:0]  bcd;
        logic        frame;
        logic [15:0] fbcd;
        logic        ferr;
        int          at_cyc;   // -1 = timing not checked
    } exp_t;

    exp_t exp_q[$];

    seg7_scan_reader #(
        .NUM_DIGITS    (4),
        .STABLE_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .seg         (seg),
        .dig_sel     (dig_sel),
        .digit_valid (digit_valid),
        .digit_idx   (digit_idx),
        .digit_bcd   (digit_bcd),
        .bcd_out     (bcd_out),
        .frame_valid (frame_valid),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push(input int pos, input logic [3:0] bcd, input logic frame,
                        input logic [15:0] fbcd, input logic ferr, input int at_cyc);
        exp_t e;
        e.idx = 3'(pos); e.bcd = bcd; e.frame = frame;
        e.fbcd = fbcd; e.ferr = ferr; e.at_cyc = at_cyc;
        exp_q.push_back(e);
    endtask

    task automatic hold(input logic [6:0] s, input logic [3:0] d, input int n);
        seg = s;
        dig_sel = d;
        repeat (n) @(negedge clk);
    endtask

    // One digit held 6 cycles followed by 2 blank cycles
    task automatic scan(input int pos, input logic [6:0] s, input logic [3:0] bcd,
                        input logic frame, input logic [15:0] fbcd, input logic ferr);
        push(pos, bcd, frame, fbcd, ferr, -1);
        hold(s, 4'(1 << pos), 6);
        hold(7'h00, 4'b0000, 2);
    endtask

    task automatic do_reset(input string name);
        rst = 1'b1;
        seg = '0;
        dig_sel = '0;
        @(negedge clk);
        chk({name, "_valid"}, {31'd0, digit_valid}, 0);
        chk({name, "_idx"}, {29'd0, digit_idx}, 0);
        chk({name, "_bcd"}, {28'd0, digit_bcd}, 0);
        chk({name, "_out"}, {16'd0, bcd_out}, 0);
        chk({name, "_fvalid"}, {31'd0, frame_valid}, 0);
        chk({name, "_ferr"}, {31'd0, frame_err}, 0);
        rst = 1'b0;
    endtask

    // Monitor: every digit_valid pops one expectation; frame_valid must coincide
    always @(negedge clk) begin
        if (digit_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_digit", {29'd0, digit_idx}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("digit_idx", {29'd0, digit_idx}, {29'd0, e.idx});
                chk("digit_bcd", {28'd0, digit_bcd}, {28'd0, e.bcd});
                chk("frame_with_digit", {31'd0, frame_valid}, {31'd0, e.frame});
                if (e.frame) begin
                    chk("bcd_out", {16'd0, bcd_out}, {16'd0, e.fbcd});
                    chk("frame_err", {31'd0, frame_err}, {31'd0, e.ferr});
                end
                if (e.at_cyc >= 0)
                    chk("accept_latency", cyc, e.at_cyc);
            end
        end else if (frame_valid) begin
            chk("frame_without_digit", {31'd0, frame_valid}, 0);
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        do_reset("reset");

        // Single held digit: one accept 4 edges after the first sampling edge
        push(0, 4'd0, 1'b0, 16'h0, 1'b0, cyc + 5);
        hold(7'h7E, 4'b0001, 10);
        hold(7'h00, 4'b0000, 2);
        do_reset("reset2");
        hold(7'h00, 4'b0000, 2);

        // Clean frame 9371
        scan(3, 7'h7B, 4'd9, 1'b0, 16'h0, 1'b0);
        scan(2, 7'h79, 4'd3, 1'b0, 16'h0, 1'b0);
        scan(1, 7'h70, 4'd7, 1'b0, 16'h0, 1'b0);
        scan(0, 7'h30, 4'd1, 1'b1, 16'h9371, 1'b0);
        chk("hold_9371", {16'd0, bcd_out}, 32'h9371);

        // Blank and invalid patterns
        scan(3, 7'h7E, 4'd0, 1'b0, 16'h0, 1'b0);
        scan(2, 7'h00, 4'hF, 1'b0, 16'h0, 1'b0);
        scan(1, 7'h0F, 4'hE, 1'b0, 16'h0, 1'b0);
        scan(0, 7'h7E, 4'd0, 1'b1, 16'h0FE0, 1'b1);

        // Error accumulator must have cleared
        scan(3, 7'h7F, 4'd8, 1'b0, 16'h0, 1'b0);
        scan(2, 7'h7F, 4'd8, 1'b0, 16'h0, 1'b0);
        scan(1, 7'h7F, 4'd8, 1'b0, 16'h0, 1'b0);
        scan(0, 7'h7F, 4'd8, 1'b1, 16'h8888, 1'b0);

        // Glitch: 3-cycle pattern never accepted, following 5-cycle one is
        push(0, 4'd4, 1'b0, 16'h0, 1'b0, -1);
        hold(7'h30, 4'b0001, 3);
        hold(7'h33, 4'b0001, 5);
        hold(7'h00, 4'b0000, 2);

        // Multi-hot select is blanking
        hold(7'h7E, 4'b0011, 10);
        hold(7'h00, 4'b0000, 2);

        // Position 0 re-accepted; latest value wins
        push(0, 4'd5, 1'b0, 16'h0, 1'b0, -1);
        hold(7'h5B, 4'b0001, 6);
        push(0, 4'd6, 1'b0, 16'h0, 1'b0, -1);
        hold(7'h5F, 4'b0001, 6);
        hold(7'h00, 4'b0000, 2);
        scan(1, 7'h7E, 4'd0, 1'b0, 16'h0, 1'b0);
        scan(2, 7'h30, 4'd1, 1'b0, 16'h0, 1'b0);
        scan(3, 7'h6D, 4'd2, 1'b1, 16'h2106, 1'b0);

        // Reset mid-dwell with three positions already seen
        scan(0, 7'h7E, 4'd0, 1'b0, 16'h0, 1'b0);
        scan(1, 7'h30, 4'd1, 1'b0, 16'h0, 1'b0);
        scan(2, 7'h6D, 4'd2, 1'b0, 16'h0, 1'b0);
        hold(7'h7B, 4'b1000, 2);
        do_reset("mid_reset");
        hold(7'h00, 4'b0000, 2);
        scan(3, 7'h7B, 4'd9, 1'b0, 16'h0, 1'b0);
        scan(0, 7'h5B, 4'd5, 1'b0, 16'h0, 1'b0);
        scan(1, 7'h33, 4'd4, 1'b0, 16'h0, 1'b0);
        scan(2, 7'h79, 4'd3, 1'b1, 16'h9345, 1'b0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        repeat (5) @(negedge clk);
        chk("hold_9345", {16'd0, bcd_out}, 32'h9345);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg7_scan_reader.md
Name: seg7_scan_reader

Overview:
- Receive end of the BCD-to-7-segment path: watches a multiplexed, active-high 7-segment bus plus its one-hot digit-select lines and recovers the displayed BCD digits.
- Each digit pattern must hold stable for a programmable dwell before it is accepted and decoded.
- Once every digit position has been captured, the block publishes one packed multi-digit BCD word with an error flag.
- Used as a display-readback monitor and as a self-check partner for the segment encoder.

Parameters:
NUM_DIGITS, 4, number of multiplexed digit positions (1..8)
STABLE_CYCLES, 4, consecutive identical registered samples required before a digit is accepted (>=1)

Ports:
clk  input  1  single system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
seg  input  7  segment bus, seg[6]=a .. seg[0]=g, 1 = lit
dig_sel  input  NUM_DIGITS  one-hot digit select, bit i = position i (0 = least significant digit)
digit_valid  output  1  one-cycle pulse: a digit was accepted
digit_idx  output  3  position of the accepted digit, valid with digit_valid
digit_bcd  output  4  decoded code of the accepted digit, valid with digit_valid
bcd_out  output  4*NUM_DIGITS  last complete frame; digit i in bits [4i+3:4i]
frame_valid  output  1  one-cycle pulse: bcd_out updated this cycle
frame_err  output  1  valid with frame_valid: the frame contained an invalid pattern

Behaviour:
- Reset: all outputs 0. Input registers, stability counter, seen-mask and error accumulator are cleared. Reset asserted mid-dwell or mid-frame discards all partial state; the first accept after reset needs a full dwell.
- Input stage: seg and dig_sel are registered every cycle as seg_q and sel_q.
- Stability counter: cnt increments, saturating at STABLE_CYCLES, while seg_q and sel_q equal their previous values and sel_q is one-hot. Otherwise cnt loads 1 if sel_q is one-hot, else 0.
- Blanking: dig_sel all-zero or multi-hot is a blanking interval. No accept occurs and the counter is held at 0.
- Accept: fires on the single cycle where cnt becomes STABLE_CYCLES, so there is exactly one accept per dwell. Holding a pattern longer never re-accepts.
- Accept timing: inputs are applied before edge k and held. digit_valid is high in the cycle following edge k+STABLE_CYCLES and is registered.
- Decode, seg to code:
  - 7E=0, 30=1, 6D=2, 79=3, 33=4, 5B=5, 5F=6, 70=7, 7F=8, 7B=9.
  - 00 = blank, which gives 4'hF and is not an error.
  - Any other pattern gives 4'hE and sets the frame error accumulator.
- Frame assembly:
  - On accept, the digit is written to a shadow register slot and seen[idx] is set.
  - A repeated accept of the same position inside one frame overwrites the slot; latest wins, no error.
  - When seen becomes all ones (including the current accept), bcd_out, frame_valid and frame_err update in the same cycle as that digit_valid.
  - In that same cycle, seen and the error accumulator clear.
- Simultaneous events: a frame completion and the accept that completes it are the same event. The next accept starts a fresh frame.
- bcd_out holds its value between frame_valid pulses.
- Widths: digit_idx is zero-extended from clog2(NUM_DIGITS). cnt is clog2(STABLE_CYCLES+1) bits.

Decomposition:
- Package seg7_pkg holds:
  - segment constants SEG_0..SEG_9 and SEG_BLANK;
  - code constants BCD_BLANK=4'hF and BCD_INVALID=4'hE;
  - the segment bit-order localparams.
- Sub-module seg7_pattern_decode: purely combinational, seg[6:0] in, code[3:0] plus invalid out. It is reused by other monitors.
- seg7_scan_reader contains the input registers, stability counter, one-hot check, seen-mask and frame registers.

Test Plan:
- Reset then hold seg=7E with dig_sel=0001 for 10 cycles, STABLE_CYCLES=4 -> exactly one digit_valid, 5 cycles after the first sampling edge, with digit_idx=0 and digit_bcd=0; no frame_valid.
- Scan 9,3,7,1 onto positions 3..0, each held 6 cycles with 2 blank cycles between -> frame_valid once with bcd_out=16'h9371, frame_err=0, asserted in the same cycle as the 4th digit_valid.
- Position 2 shows seg=00 and position 1 shows seg=0F, others 7E -> bcd_out=16'h0FE0 and frame_err=1. The next clean frame of 7F on all positions gives 16'h8888 with frame_err=0.
- Glitch: hold 30 for 3 cycles, change to 33 and hold 5 cycles -> a single accept with digit_bcd=4; no accept of 1.
- Multi-hot dig_sel=0011 for 10 cycles -> no digit_valid. Position 0 accepted twice (5B then 5F) before the frame completes -> bcd_out[3:0]=6.
- Assert rst for 1 cycle while position 3 is 2 cycles into its dwell with 3 digits already seen -> all outputs 0. That dwell does not accept, and a full 4-digit scan is required before the next frame_valid.
